// File: rtl/tile_draw_engine_pkg.sv
// Shared definitions for the tile draw engine: screen geometry, colour
// constants, FSM state encoding and the row-visibility helper.
package tile_draw_engine_pkg;

    localparam int SCREEN_W  = 160;
    localparam int SCREEN_H  = 120;
    localparam int NUM_LANES = 4;

    localparam logic [8:0] CLR_BLACK = 9'h000;
    localparam logic [8:0] CLR_WHITE = 9'h1FF;
    localparam logic [8:0] CLR_RED   = 9'h1C0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DRAW = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // An absolute row is drawable only if it lands on the visible screen.
    function automatic logic row_visible(input logic [7:0] abs_row);
        return abs_row < 8'(SCREEN_H);
    endfunction

endpackage

// File: rtl/tile_draw_engine_rect_scanner.sv
// Row-major rectangle scanner: loadable column/row counters bounded by
// width/height, with a flag marking the final pixel (width-1, height-1).
module rect_scanner (
    input  logic       clock,
    input  logic       resetn,
    input  logic       load,
    input  logic       advance,
    input  logic [7:0] width,
    input  logic [6:0] height,
    output logic [7:0] col,
    output logic [6:0] row,
    output logic       last
);

    logic col_end;
    logic row_end;

    assign col_end = (col == width - 8'd1);
    assign row_end = (row == height - 7'd1);
    assign last    = col_end && row_end;

    // Column steps first; on the right edge it wraps and the row steps.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            col <= '0;
            row <= '0;
        end else if (load) begin
            col <= '0;
            row <= '0;
        end else if (advance) begin
            if (col_end) begin
                col <= '0;
                row <= row + 7'd1;
            end else begin
                col <= col + 8'd1;
            end
        end
    end

endmodule

// File: rtl/tile_draw_engine.sv
// Rectangle-fill plotter feeding a 160x120 9-bit framebuffer adapter.
// Accepts one tile/clear request at a time and emits one registered pixel
// per clock. Optional feature macro TILE_BORDER_EN paints the outline of
// tile requests (not clears) with BORDER_CLR.
module tile_draw_engine
    import tile_draw_engine_pkg::*;
#(
    parameter int         TILE_H     = 30,
    parameter int         LANE_W     = 40,
    parameter logic [8:0] BORDER_CLR = 9'h000
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_clear,
    input  logic [1:0] req_lane,
    input  logic [6:0] req_y,
    input  logic [8:0] req_color,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [8:0] color,
    output logic       write,
    output logic       done
);

    state_t     state;
    state_t     next_state;
    logic       load;
    logic       advance;

    logic       clear_q;
    logic [7:0] x_org;
    logic [6:0] y_org;
    logic [8:0] fill_clr;

    logic [7:0] width;
    logic [6:0] height;
    logic [7:0] col;
    logic [6:0] row;
    logic       last;

    logic [7:0] x_abs;
    logic [7:0] row_abs;
    logic       border_sel;
    logic [8:0] pix_clr;

    // State register; reset aborts any draw in progress.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= next_state;
    end

    // Next-state and handshake decode.
    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        load       = 1'b0;
        advance    = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    load       = 1'b1;
                    next_state = ST_DRAW;
                end
            end
            ST_DRAW: begin
                advance = 1'b1;
                if (last) next_state = ST_DONE;
            end
            ST_DONE: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // Capture the request; a clear always originates at (0,0).
    always_ff @(posedge clock) begin
        if (load) begin
            clear_q  <= req_clear;
            x_org    <= req_clear ? 8'd0 : 8'(int'(req_lane) * LANE_W);
            y_org    <= req_clear ? 7'd0 : req_y;
            fill_clr <= req_color;
        end
    end

    assign width  = clear_q ? 8'(SCREEN_W) : 8'(LANE_W);
    assign height = clear_q ? 7'(SCREEN_H) : 7'(TILE_H);

    rect_scanner u_scanner (
        .clock   (clock),
        .resetn  (resetn),
        .load    (load),
        .advance (advance),
        .width   (width),
        .height  (height),
        .col     (col),
        .row     (row),
        .last    (last)
    );

    // Absolute row kept in 8 bits so rows past the bottom clip instead of wrapping.
    assign x_abs   = x_org + col;
    assign row_abs = {1'b0, y_org} + {1'b0, row};

`ifdef TILE_BORDER_EN
    assign border_sel = !clear_q &&
                        ((col == 8'd0) || (col == width - 8'd1) ||
                         (row == 7'd0) || (row == height - 7'd1));
`else
    assign border_sel = 1'b0;
`endif

    assign pix_clr = border_sel ? BORDER_CLR : fill_clr;

    // Registered pixel outputs; clipped slots still consume a cycle with write low.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            write <= 1'b0;
            done  <= 1'b0;
            x     <= '0;
            y     <= '0;
            color <= '0;
        end else begin
            write <= (state == ST_DRAW) && row_visible(row_abs);
            done  <= (state == ST_DONE);
            if (state == ST_DRAW) begin
                x     <= x_abs;
                y     <= row_abs[6:0];
                color <= pix_clr;
            end
        end
    end

endmodule
